// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings, command record and helpers for the memory arbiter.
// Macro CIRNO9_ARB_STARVE_EN (used by mem_arb) enables IF starvation protection.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] OW_NONE = 2'd0;
    localparam logic [1:0] OW_IF   = 2'd1;
    localparam logic [1:0] OW_AG   = 2'd2;
    localparam logic [1:0] OW_AXIS = 2'd3;

    localparam int STARVE_LIMIT_DEF = 8;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  wen;
        logic        ren;
    } cmd_t;

    // Grant vector bit order: [0]=IF, [1]=AG, [2]=AXIS.
    function automatic logic [1:0] gnt2owner(input logic [2:0] gnt);
        return gnt[2] ? OW_AXIS : gnt[1] ? OW_AG : gnt[0] ? OW_IF : OW_NONE;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational 3-way priority picker producing a one-hot grant.
// Ports:
//   i_val    [2:0] request valids, [0]=IF [1]=AG [2]=AXIS
//   i_starve       IF is starved: promote IF to top priority
//   o_gnt    [2:0] one-hot grant, same bit order as i_val
module mem_arb_pick (
    input  logic [2:0] i_val,
    input  logic       i_starve,
    output logic [2:0] o_gnt
);

    // Normal order AXIS > AG > IF; a starved IF jumps ahead, leaving AXIS > AG behind it.
    always_comb begin
        o_gnt = (i_starve && i_val[0]) ? 3'b001 :
                i_val[2]               ? 3'b100 :
                i_val[1]               ? 3'b010 :
                i_val[0]               ? 3'b001 : 3'b000;
    end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: single-outstanding arbiter from IF / AG / AXIS requesters to the shared memory port.
// Macro CIRNO9_ARB_STARVE_EN: adds an IF starvation counter that promotes IF after
// STARVE_LIMIT consecutive lost IDLE cycles. Without it priority is strictly AXIS > AG > IF.
// Ports:
//   i_clk, i_rst                      clock, asynchronous active-high reset
//   hs_*4arb_val / hs_arb4*_rdy       requester handshakes (ready only in IDLE, one-hot)
//   i_if_adr                          IF read address
//   i_ag_* / i_axis_*                 AG / AXIS address, write data, byte enables, read enable
//   hs_arb4mem_val / hs_mem4arb_rdy   registered command handshake to the memory port
//   o_mem_adr/wdat/wen/ren            command fields, stable while hs_arb4mem_val is high
//   i_mem_rvld / i_mem_rdat           read return, one pulse per read
//   o_rdat                            registered read data, held until the next read completes
//   o_if_rvld/o_ag_rvld/o_axis_rvld   one-cycle read-data valid to the owning requester
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        hs_if4arb_val,
    output logic        hs_arb4if_rdy,
    input  logic [31:0] i_if_adr,
    input  logic        hs_ag4arb_val,
    output logic        hs_arb4ag_rdy,
    input  logic [31:0] i_ag_adr,
    input  logic [31:0] i_ag_wdat,
    input  logic [3:0]  i_ag_wen,
    input  logic        i_ag_ren,
    input  logic        hs_axis4arb_val,
    output logic        hs_arb4axis_rdy,
    input  logic [31:0] i_axis_adr,
    input  logic [31:0] i_axis_wdat,
    input  logic [3:0]  i_axis_wen,
    input  logic        i_axis_ren,
    output logic        hs_arb4mem_val,
    input  logic        hs_mem4arb_rdy,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_wdat,
    output logic [3:0]  o_mem_wen,
    output logic        o_mem_ren,
    input  logic        i_mem_rvld,
    input  logic [31:0] i_mem_rdat,
    output logic [31:0] o_rdat,
    output logic        o_if_rvld,
    output logic        o_ag_rvld,
    output logic        o_axis_rvld
);

    logic [1:0]  r_state;
    logic [1:0]  r_owner;
    cmd_t        r_cmd;
    logic [31:0] r_rdat;
    logic [2:0]  r_rvld;

    logic        w_idle;
    logic        w_starve;
    logic [2:0]  w_gnt;
    cmd_t        w_win;

    assign w_idle = (r_state == ST_IDLE);

    mem_arb_pick u_pick (
        .i_val    ({hs_axis4arb_val, hs_ag4arb_val, hs_if4arb_val} & {3{w_idle}}),
        .i_starve (w_starve),
        .o_gnt    (w_gnt)
    );

`ifdef CIRNO9_ARB_STARVE_EN
    logic [7:0] r_starve;

    // Counts IDLE cycles where IF asked but someone else won; saturates at the limit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_starve <= '0;
        else if (w_gnt[0])
            r_starve <= '0;
        else if (w_idle && hs_if4arb_val && r_starve != 8'(STARVE_LIMIT))
            r_starve <= r_starve + 8'd1;
    end

    assign w_starve = (r_starve == 8'(STARVE_LIMIT));
`else
    // No counter in this build; the limit is 1..255 so this is constant 0.
    assign w_starve = (STARVE_LIMIT == 0);
`endif

    assign {hs_arb4axis_rdy, hs_arb4ag_rdy, hs_arb4if_rdy} = w_gnt;

    // IF only ever reads a full word, so its write fields are forced to zero.
    always_comb begin
        w_win = '{adr: i_if_adr, wdat: 32'd0, wen: 4'd0, ren: 1'b1};
        if (w_gnt[2])
            w_win = '{adr: i_axis_adr, wdat: i_axis_wdat, wen: i_axis_wen, ren: i_axis_ren};
        else if (w_gnt[1])
            w_win = '{adr: i_ag_adr, wdat: i_ag_wdat, wen: i_ag_wen, ren: i_ag_ren};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_owner <= OW_NONE;
            r_cmd   <= '0;
            r_rdat  <= '0;
            r_rvld  <= '0;
        end else begin
            r_rvld <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_cmd   <= w_win;
                        r_owner <= gnt2owner(w_gnt);
                        r_state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    // ren wins over wen: a mixed command waits for read data.
                    if (hs_mem4arb_rdy) begin
                        if (r_cmd.ren) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_IDLE;
                            r_owner <= OW_NONE;
                        end
                    end
                end
                ST_RESP: begin
                    if (i_mem_rvld) begin
                        r_rdat  <= i_mem_rdat;
                        r_rvld  <= {r_owner == OW_AXIS, r_owner == OW_AG, r_owner == OW_IF};
                        r_state <= ST_IDLE;
                        r_owner <= OW_NONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_owner <= OW_NONE;
                end
            endcase
        end
    end

    assign hs_arb4mem_val = (r_state == ST_CMD);
    assign o_mem_adr      = r_cmd.adr;
    assign o_mem_wdat     = r_cmd.wdat;
    assign o_mem_wen      = r_cmd.wen;
    assign o_mem_ren      = r_cmd.ren;
    assign o_rdat         = r_rdat;
    assign o_if_rvld      = r_rvld[0];
    assign o_ag_rvld      = r_rvld[1];
    assign o_axis_rvld    = r_rvld[2];

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed plus randomized bench for mem_arb against a transaction-level model.
module tb_mem_arb;

    localparam int LIM = 3;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        hs_if4arb_val, hs_arb4if_rdy;
    logic [31:0] i_if_adr;
    logic        hs_ag4arb_val, hs_arb4ag_rdy;
    logic [31:0] i_ag_adr, i_ag_wdat;
    logic [3:0]  i_ag_wen;
    logic        i_ag_ren;
    logic        hs_axis4arb_val, hs_arb4axis_rdy;
    logic [31:0] i_axis_adr, i_axis_wdat;
    logic [3:0]  i_axis_wen;
    logic        i_axis_ren;
    logic        hs_arb4mem_val, hs_mem4arb_rdy;
    logic [31:0] o_mem_adr, o_mem_wdat;
    logic [3:0]  o_mem_wen;
    logic        o_mem_ren;
    logic        i_mem_rvld;
    logic [31:0] i_mem_rdat, o_rdat;
    logic        o_if_rvld, o_ag_rvld, o_axis_rvld;

    mem_arb #(.STARVE_LIMIT(LIM)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .hs_if4arb_val(hs_if4arb_val), .hs_arb4if_rdy(hs_arb4if_rdy), .i_if_adr(i_if_adr),
        .hs_ag4arb_val(hs_ag4arb_val), .hs_arb4ag_rdy(hs_arb4ag_rdy), .i_ag_adr(i_ag_adr),
        .i_ag_wdat(i_ag_wdat), .i_ag_wen(i_ag_wen), .i_ag_ren(i_ag_ren),
        .hs_axis4arb_val(hs_axis4arb_val), .hs_arb4axis_rdy(hs_arb4axis_rdy), .i_axis_adr(i_axis_adr),
        .i_axis_wdat(i_axis_wdat), .i_axis_wen(i_axis_wen), .i_axis_ren(i_axis_ren),
        .hs_arb4mem_val(hs_arb4mem_val), .hs_mem4arb_rdy(hs_mem4arb_rdy),
        .o_mem_adr(o_mem_adr), .o_mem_wdat(o_mem_wdat), .o_mem_wen(o_mem_wen), .o_mem_ren(o_mem_ren),
        .i_mem_rvld(i_mem_rvld), .i_mem_rdat(i_mem_rdat), .o_rdat(o_rdat),
        .o_if_rvld(o_if_rvld), .o_ag_rvld(o_ag_rvld), .o_axis_rvld(o_axis_rvld)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;
    int n_if_gnt = 0;

    // Model: one pending transaction (who, what, whether the port took it), last read data,
    // which requester is owed a data pulse this cycle, and the IF starvation count.
    bit          m_txn, m_acc;
    int          m_own, m_pulse, m_cnt;
    logic [31:0] m_adr, m_wdat, m_rdat;
    logic [3:0]  m_wen;
    logic        m_ren;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_txn = 0; m_acc = 0; m_own = 0; m_pulse = 0; m_cnt = 0;
        m_adr = '0; m_wdat = '0; m_wen = '0; m_ren = 1'b0; m_rdat = '0;
    endtask

    task automatic clear_inputs();
        hs_if4arb_val = 0; i_if_adr = '0;
        hs_ag4arb_val = 0; i_ag_adr = '0; i_ag_wdat = '0; i_ag_wen = '0; i_ag_ren = 0;
        hs_axis4arb_val = 0; i_axis_adr = '0; i_axis_wdat = '0; i_axis_wen = '0; i_axis_ren = 0;
        hs_mem4arb_rdy = 0; i_mem_rvld = 0; i_mem_rdat = '0;
    endtask

    task automatic rand_inputs();
        hs_if4arb_val = ($urandom_range(0, 2) == 0); i_if_adr = $urandom;
        hs_ag4arb_val = ($urandom_range(0, 2) == 0); i_ag_adr = $urandom; i_ag_wdat = $urandom;
        i_ag_wen = 4'($urandom); i_ag_ren = 1'($urandom);
        hs_axis4arb_val = ($urandom_range(0, 3) == 0); i_axis_adr = $urandom; i_axis_wdat = $urandom;
        i_axis_wen = 4'($urandom); i_axis_ren = 1'($urandom);
        hs_mem4arb_rdy = 1'($urandom); i_mem_rvld = ($urandom_range(0, 2) == 0); i_mem_rdat = $urandom;
    endtask

    // Called just after a rising edge with inputs already driven; checks at the falling edge.
    task automatic cyc();
        int  w;
        logic pri_if;
        @(negedge i_clk);
        pri_if = 1'b0;
`ifdef CIRNO9_ARB_STARVE_EN
        pri_if = (m_cnt == LIM);
`endif
        w = 0;
        if (!m_txn) begin
            if (pri_if && hs_if4arb_val) w = 1;
            else if (hs_axis4arb_val) w = 3;
            else if (hs_ag4arb_val) w = 2;
            else if (hs_if4arb_val) w = 1;
        end
        if (hs_arb4if_rdy) n_if_gnt++;
        chk("if_rdy", hs_arb4if_rdy, w == 1);
        chk("ag_rdy", hs_arb4ag_rdy, w == 2);
        chk("axis_rdy", hs_arb4axis_rdy, w == 3);
        chk("mem_val", hs_arb4mem_val, m_txn && !m_acc);
        if (m_txn && !m_acc) begin
            chk("mem_adr", o_mem_adr, m_adr);
            chk("mem_wdat", o_mem_wdat, m_wdat);
            chk("mem_wen", o_mem_wen, m_wen);
            chk("mem_ren", o_mem_ren, m_ren);
        end
        chk("if_rvld", o_if_rvld, m_pulse == 1);
        chk("ag_rvld", o_ag_rvld, m_pulse == 2);
        chk("axis_rvld", o_axis_rvld, m_pulse == 3);
        chk("rdat", o_rdat, m_rdat);
        if (!m_txn && hs_if4arb_val) m_cnt = (w == 1) ? 0 : (m_cnt < LIM ? m_cnt + 1 : m_cnt);
        m_pulse = 0;
        if (m_txn && m_acc) begin
            if (i_mem_rvld) begin
                m_pulse = m_own; m_rdat = i_mem_rdat; m_txn = 0;
            end
        end else if (m_txn) begin
            if (hs_mem4arb_rdy) begin
                if (m_ren) m_acc = 1; else m_txn = 0;
            end
        end else if (w != 0) begin
            m_txn = 1; m_acc = 0; m_own = w;
            case (w)
                1: begin m_adr = i_if_adr; m_wdat = '0; m_wen = '0; m_ren = 1'b1; end
                2: begin m_adr = i_ag_adr; m_wdat = i_ag_wdat; m_wen = i_ag_wen; m_ren = i_ag_ren; end
                default: begin m_adr = i_axis_adr; m_wdat = i_axis_wdat; m_wen = i_axis_wen; m_ren = i_axis_ren; end
            endcase
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        clear_inputs();
        #1;
        chk("rst_mem_val", hs_arb4mem_val, 0);
        chk("rst_mem_adr", o_mem_adr, 0);
        chk("rst_mem_wdat", o_mem_wdat, 0);
        chk("rst_mem_wen_ren", {o_mem_wen, o_mem_ren}, 0);
        chk("rst_rdat", o_rdat, 0);
        chk("rst_rvld", {o_if_rvld, o_ag_rvld, o_axis_rvld}, 0);
        chk("rst_rdy", {hs_arb4if_rdy, hs_arb4ag_rdy, hs_arb4axis_rdy}, 0);
        model_reset();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    initial begin
        int snap;
        int hold_adr;
        clear_inputs();
        do_reset();

        // IF read, single-cycle memory latency
        hs_if4arb_val = 1; i_if_adr = 32'h8000_0010;
        cyc();
        hs_if4arb_val = 0; hs_mem4arb_rdy = 1;
        cyc();
        hs_mem4arb_rdy = 0; i_mem_rvld = 1; i_mem_rdat = 32'hDEAD_BEEF;
        cyc();
        i_mem_rvld = 0;
        cyc();
        chk("t1_rdat", o_rdat, 32'hDEAD_BEEF);

        // stray read data in IDLE
        i_mem_rvld = 1; i_mem_rdat = 32'h55;
        cyc();
        i_mem_rvld = 0;
        cyc();
        chk("t6_rdat", o_rdat, 32'hDEAD_BEEF);

        // AG write beats IF; IF wins the first IDLE cycle after
        hs_ag4arb_val = 1; i_ag_adr = 32'h8000_0020; i_ag_wdat = 32'h1234_5678; i_ag_wen = 4'hF; i_ag_ren = 0;
        hs_if4arb_val = 1; i_if_adr = 32'h8000_0100;
        cyc();
        chk("t2_wen", o_mem_wen, 4'hF);
        hs_ag4arb_val = 0; hs_mem4arb_rdy = 1;
        cyc();
        hs_mem4arb_rdy = 0;
        snap = n_if_gnt;
        cyc();
        chk("t2_if_gnt", n_if_gnt - snap, 1);
        hs_if4arb_val = 0; hs_mem4arb_rdy = 1;
        cyc();
        hs_mem4arb_rdy = 0; i_mem_rvld = 1; i_mem_rdat = 32'hA5A5_0001;
        cyc();
        i_mem_rvld = 0;
        cyc();

        // AXIS read held off by the memory port for 5 cycles, others requesting meanwhile
        hs_axis4arb_val = 1; i_axis_adr = 32'h4000_0040; i_axis_ren = 1; i_axis_wen = 4'h3; i_axis_wdat = 32'hCAFE_F00D;
        cyc();
        hs_axis4arb_val = 0; hs_ag4arb_val = 1; hs_if4arb_val = 1;
        hold_adr = 32'h4000_0040;
        for (int i = 0; i < 5; i++) begin
            i_axis_adr = $urandom; i_axis_wdat = $urandom; i_axis_wen = 4'($urandom);
            cyc();
            chk("t3_hold_adr", o_mem_adr, hold_adr);
        end
        hs_ag4arb_val = 0; hs_if4arb_val = 0; hs_mem4arb_rdy = 1;
        cyc();
        hs_mem4arb_rdy = 0; i_mem_rvld = 1; i_mem_rdat = 32'h0BAD_CAFE;
        cyc();
        i_mem_rvld = 0;
        cyc();

        // AXIS writes back to back with IF waiting
        do_reset();
        hs_axis4arb_val = 1; i_axis_ren = 0; i_axis_wen = 4'hF; i_axis_adr = 32'h4000_0000;
        hs_if4arb_val = 1; i_if_adr = 32'h8000_0200;
        hs_mem4arb_rdy = 1; i_mem_rvld = 1; i_mem_rdat = 32'h1111_2222;
        snap = n_if_gnt;
        for (int i = 0; i < 12; i++) cyc();
`ifdef CIRNO9_ARB_STARVE_EN
        chk("t4_if_gnt", n_if_gnt - snap, 1);
`else
        chk("t4_if_gnt", n_if_gnt - snap, 0);
`endif
        clear_inputs(); hs_mem4arb_rdy = 1;
        cyc(); cyc();

        // reset while waiting in RESP, then a late response
        clear_inputs();
        hs_axis4arb_val = 1; i_axis_ren = 1; i_axis_adr = 32'h4000_0080;
        cyc();
        hs_axis4arb_val = 0; hs_mem4arb_rdy = 1;
        cyc();
        hs_mem4arb_rdy = 0;
        cyc(); cyc();
        do_reset();
        i_mem_rvld = 1; i_mem_rdat = 32'h7777_7777;
        cyc();
        i_mem_rvld = 0;
        cyc();
        chk("t5_rdat", o_rdat, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            rand_inputs();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
